// File: rtl/riesgos_pkg.sv
// ---------------------------------------------------------------------------
// riesgos_pkg
// Shared definitions for the MIPS pipeline hazard controller:
//   - state_t      : controller state encoding (RUN, STALL, HALT, STEP_WAIT)
//   - REG_ZERO     : address of the hard-wired zero register
//   - *_DEF        : default widths / latencies used by the modules
// ---------------------------------------------------------------------------
package riesgos_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_STALL     = 2'd1,
    ST_HALT      = 2'd2,
    ST_STEP_WAIT = 2'd3
  } state_t;

  // Register $0 is never really written, so it can never carry a hazard.
  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int NB_ADDR_DEF     = 5;
  localparam int MEM_LATENCY_DEF = 1;
  localparam int PIPE_DEPTH_DEF  = 3;
  localparam int NB_CNT_DEF      = 3;

endpackage

// File: rtl/control_riesgos_pipeline_detector.sv
// ---------------------------------------------------------------------------
// detector_load_use
// Purely combinational load-use comparator. Flags a hazard when the valid
// instruction in ID reads a register that the load currently in EX is going
// to write.
// Ports:
//   valid_id    : ID instruction is valid
//   rs_id/rt_id : source register fields of the ID instruction
//   uses_rs/rt  : ID instruction really reads rs / rt
//   ex_mem_read : instruction in EX is a load
//   ex_rt       : destination register of the load in EX
//   hz          : load-use hazard detected
// ---------------------------------------------------------------------------
module detector_load_use
  import riesgos_pkg::*;
#(
  parameter int NB_address_registros = NB_ADDR_DEF
) (
  input  logic                            valid_id,
  input  logic [NB_address_registros-1:0] rs_id,
  input  logic [NB_address_registros-1:0] rt_id,
  input  logic                            uses_rs,
  input  logic                            uses_rt,
  input  logic                            ex_mem_read,
  input  logic [NB_address_registros-1:0] ex_rt,
  output logic                            hz
);

  logic ex_dest_real;
  logic rs_match;
  logic rt_match;

  // A load targeting $0 writes nothing useful, so it never blocks a reader.
  assign ex_dest_real = (ex_rt != NB_address_registros'(REG_ZERO));

  // Only fields the instruction actually reads may raise a hazard; a
  // coincidental match on an unused field (e.g. rt of an I-type dest) is noise.
  assign rs_match = uses_rs && (rs_id == ex_rt);
  assign rt_match = uses_rt && (rt_id == ex_rt);

  assign hz = valid_id && ex_mem_read && ex_dest_real && (rs_match || rt_match);

endmodule

// File: rtl/control_riesgos_pipeline.sv
// ---------------------------------------------------------------------------
// control_riesgos_pipeline
// Hazard and sequencing controller for the 5-stage MIPS pipeline, placed next
// to the ID stage. It stalls PC and IF/ID on load-use hazards (bubbling
// ID/EX), flushes IF/ID on taken branches and jumps, and sequences HALT by
// freezing fetch and draining EX/MEM/WB before reporting halted.
//
// Optional feature macro: STEP_MODE_EN
//   When defined, adds i_debug_mode / i_step for single-step execution.
//
// Ports:
//   i_clk, i_rst        : clock (rising edge), async active-low reset
//   i_valid_id          : ID instruction valid
//   i_rs_id, i_rt_id    : ID source register fields
//   i_uses_rs, i_uses_rt: ID instruction reads rs / rt
//   i_ex_mem_read       : instruction in EX is a load
//   i_ex_rt             : destination of the load in EX
//   i_branch_taken      : branch resolved taken in ID
//   i_jump              : ID instruction is a jump
//   i_halt              : ID instruction is HALT
//   i_debug_mode, i_step: (STEP_MODE_EN only) debug park and step request
//   o_pc_write          : PC update enable
//   o_if_id_write       : IF/ID latch enable
//   o_if_id_flush       : clear IF/ID to NOP
//   o_id_ex_bubble      : zero control bits going into ID/EX
//   o_pipe_en           : enable for ID/EX, EX/MEM, MEM/WB latches
//   o_halted            : HALT fully drained (registered)
//   o_state             : current controller state (registered)
// ---------------------------------------------------------------------------
module control_riesgos_pipeline
  import riesgos_pkg::*;
#(
  parameter int NB_address_registros = NB_ADDR_DEF,
  parameter int MEM_LATENCY          = MEM_LATENCY_DEF,
  parameter int PIPE_DEPTH           = PIPE_DEPTH_DEF,
  parameter int NB_CNT               = NB_CNT_DEF
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_valid_id,
  input  logic [NB_address_registros-1:0] i_rs_id,
  input  logic [NB_address_registros-1:0] i_rt_id,
  input  logic                            i_uses_rs,
  input  logic                            i_uses_rt,
  input  logic                            i_ex_mem_read,
  input  logic [NB_address_registros-1:0] i_ex_rt,
  input  logic                            i_branch_taken,
  input  logic                            i_jump,
  input  logic                            i_halt,
`ifdef STEP_MODE_EN
  input  logic                            i_debug_mode,
  input  logic                            i_step,
`endif
  output logic                            o_pc_write,
  output logic                            o_if_id_write,
  output logic                            o_if_id_flush,
  output logic                            o_id_ex_bubble,
  output logic                            o_pipe_en,
  output logic                            o_halted,
  output logic [1:0]                      o_state
);

  // The first stall cycle is spent in RUN, so the counter only has to cover
  // the remaining MEM_LATENCY-1 cycles.
  localparam logic [NB_CNT-1:0] STALL_LOAD  = NB_CNT'(MEM_LATENCY - 1);
  localparam logic [NB_CNT-1:0] DRAIN_MAX   = NB_CNT'(PIPE_DEPTH);
  localparam logic [NB_CNT-1:0] CNT_ONE     = NB_CNT'(1);
  localparam bit                MULTI_CYCLE = (MEM_LATENCY > 1);

  state_t            state;
  state_t            next_state;
  state_t            eval_state;
  logic              eval_en;
  logic [NB_CNT-1:0] stall_cnt;
  logic [NB_CNT-1:0] stall_next;
  logic [NB_CNT-1:0] drain_cnt;
  logic [NB_CNT-1:0] drain_next;
  logic              halted;
  logic              halted_next;
  logic              hz;

  detector_load_use #(
    .NB_address_registros(NB_address_registros)
  ) u_detector (
    .valid_id   (i_valid_id),
    .rs_id      (i_rs_id),
    .rt_id      (i_rt_id),
    .uses_rs    (i_uses_rs),
    .uses_rt    (i_uses_rt),
    .ex_mem_read(i_ex_mem_read),
    .ex_rt      (i_ex_rt),
    .hz         (hz)
  );

`ifdef STEP_MODE_EN
  logic step_q;
  logic step_pulse;

  // Remembers last cycle's i_step so a held button yields a single step.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      step_q <= 1'b0;
    end else begin
      step_q <= i_step;
    end
  end

  assign step_pulse = i_step && !step_q;
`endif

  // State, stall/drain counters and the drained flag. Reset drops any
  // in-progress stall or drain on the spot.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= ST_RUN;
      stall_cnt <= '0;
      drain_cnt <= '0;
      halted    <= 1'b0;
    end else begin
      state     <= next_state;
      stall_cnt <= stall_next;
      drain_cnt <= drain_next;
      halted    <= halted_next;
    end
  end

  // Next-state and output decode. eval_en says whether this cycle performs
  // normal pipeline work; eval_state says which behaviour (RUN/STALL/HALT)
  // that work follows. Outside single-step mode both are simply "always" and
  // "the current state".
  always_comb begin
    next_state     = state;
    stall_next     = stall_cnt;
    drain_next     = drain_cnt;
    o_pc_write     = 1'b0;
    o_if_id_write  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_pipe_en      = 1'b0;
    eval_state     = state;
    eval_en        = 1'b1;

`ifdef STEP_MODE_EN
    // While parked, a pending stall is remembered in stall_cnt, so a step
    // resumes either the stall or normal RUN evaluation.
    if (state == ST_STEP_WAIT) begin
      eval_state = (stall_cnt != '0) ? ST_STALL : ST_RUN;
      eval_en    = i_debug_mode && step_pulse;
    end else if (state == ST_HALT) begin
      eval_en    = !i_debug_mode || step_pulse;
    end else begin
      eval_en    = !i_debug_mode;
    end
`endif

    if (eval_en) begin
      o_pipe_en = 1'b1;
      case (eval_state)
        ST_HALT: begin
          o_id_ex_bubble = 1'b1;
          if (drain_cnt < DRAIN_MAX) begin
            drain_next = drain_cnt + CNT_ONE;
          end
        end

        ST_STALL: begin
          o_id_ex_bubble = 1'b1;
          stall_next     = stall_cnt - CNT_ONE;
          if (stall_cnt <= CNT_ONE) begin
            stall_next = '0;
            next_state = ST_RUN;
          end
        end

        default: begin
          o_pc_write    = 1'b1;
          o_if_id_write = 1'b1;
          // A hazard outranks HALT and flush: the dependent instruction must
          // stay in ID until its operand exists, and a branch it carries is
          // only acted on once it finally leaves the stall.
          if (hz) begin
            o_pc_write     = 1'b0;
            o_if_id_write  = 1'b0;
            o_id_ex_bubble = 1'b1;
            if (MULTI_CYCLE) begin
              next_state = ST_STALL;
              stall_next = STALL_LOAD;
            end
          end else if (i_valid_id && i_halt) begin
            next_state = ST_HALT;
            drain_next = '0;
          end else if (i_valid_id && (i_branch_taken || i_jump)) begin
            o_if_id_flush = 1'b1;
          end
        end
      endcase
    end

`ifdef STEP_MODE_EN
    // Debug mode parks everything except HALT, which is absorbing.
    if ((state != ST_HALT) && (next_state != ST_HALT)) begin
      if (i_debug_mode) begin
        next_state = ST_STEP_WAIT;
      end else if (state == ST_STEP_WAIT) begin
        next_state = (stall_next != '0) ? ST_STALL : ST_RUN;
      end
    end
`endif

    // Drained once the counter lands on PIPE_DEPTH; registered so the flag
    // shows up the cycle after the last pipeline stage has emptied.
    halted_next = (next_state == ST_HALT) && (drain_next == DRAIN_MAX);

    // While reset is asserted every enable is forced low.
    if (!i_rst) begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_if_id_flush  = 1'b0;
      o_id_ex_bubble = 1'b0;
      o_pipe_en      = 1'b0;
    end
  end

  assign o_halted = halted;
  assign o_state  = state;

endmodule

// File: doc/control_riesgos_pipeline.md
Name: control_riesgos_pipeline

Overview:
Hazard and sequencing controller for the 5-stage MIPS pipeline. It sits beside the instruction-decode stage, which contains the register bank, the RegDst mux and the main control unit.
- Detects load-use hazards against the instruction in EX and stalls PC and IF/ID.
- Inserts bubbles into ID/EX.
- Flushes IF/ID on taken branch or jump.
- Sequences HALT: freezes fetch, drains the pipeline, then reports halted.

Parameters:
NB_address_registros, 5, register address width
MEM_LATENCY, 1, cycles a load needs in MEM; total load-use stall length in cycles (range 1..7)
PIPE_DEPTH, 3, stages after ID to drain on HALT (EX, MEM, WB)
NB_CNT, 3, width of the stall and drain counters

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset: asynchronous, active-low (0 = reset asserted)
i_valid_id  in  1  the instruction in ID is valid
i_rs_id  in  NB_address_registros  rs field ([25:21]) of the ID instruction
i_rt_id  in  NB_address_registros  rt field ([20:16]) of the ID instruction
i_uses_rs  in  1  the ID instruction reads rs
i_uses_rt  in  1  the ID instruction reads rt
i_ex_mem_read  in  1  MemRead control bit of the instruction in EX
i_ex_rt  in  NB_address_registros  destination register of the load in EX
i_branch_taken  in  1  branch resolved taken in ID
i_jump  in  1  Jump control bit of the ID instruction
i_halt  in  1  ID instruction is HALT
o_pc_write  out  1  PC update enable
o_if_id_write  out  1  IF/ID latch enable
o_if_id_flush  out  1  clear IF/ID to NOP
o_id_ex_bubble  out  1  zero the control bits loaded into ID/EX
o_pipe_en  out  1  enable for the ID/EX, EX/MEM and MEM/WB latches
o_halted  out  1  HALT fully drained (registered)
o_state  out  2  current FSM state (registered)

Behaviour:
- Reset (i_rst=0): state=RUN, both counters=0.
  - Outputs during reset: o_pc_write=0, o_if_id_write=0, o_if_id_flush=0, o_id_ex_bubble=0, o_pipe_en=0, o_halted=0, o_state=RUN.
  - Reset mid-stall or mid-drain aborts immediately. No residual stall on release.
- States: RUN=0, STALL=1, HALT=2, STEP_WAIT=3. STEP_WAIT is used only with the optional feature.
- Load-use hazard (combinational): hz = i_valid_id & i_ex_mem_read & (i_ex_rt!=0) & ((i_uses_rs & i_rs_id==i_ex_rt) | (i_uses_rt & i_rt_id==i_ex_rt)).
  - Register 0 never causes a hazard.
- RUN with hz:
  - Same cycle: o_pc_write=0, o_if_id_write=0, o_id_ex_bubble=1, o_if_id_flush=0.
  - If MEM_LATENCY>1: go to STALL with cnt=MEM_LATENCY-1. Otherwise stay in RUN.
- STALL:
  - Same stall outputs as above, regardless of inputs.
  - cnt decrements on each cycle with o_pipe_en=1. When cnt==1 and it decrements, go to RUN.
  - Total stall = exactly MEM_LATENCY cycles.
- RUN, no hz, i_valid_id & i_halt:
  - The HALT instruction is allowed through this cycle (all enables 1).
  - Next state HALT, drain cnt=0.
- HALT (absorbing until reset):
  - o_pc_write=0, o_if_id_write=0, o_id_ex_bubble=1, o_pipe_en=1.
  - Drain cnt increments, saturating at PIPE_DEPTH.
  - o_halted=1 from the cycle after cnt reaches PIPE_DEPTH.
  - Branch, jump and hazard inputs are ignored.
- RUN, no hz, no halt, i_valid_id & (i_branch_taken | i_jump): o_if_id_flush=1 for that cycle; o_pc_write=1.
- Priority: reset > HALT > STALL > hz > halt > flush.
  - A branch that depends on a load stalls first; its flush is taken only after the stall ends.
  - Inputs with i_valid_id=0 are ignored.
- Default RUN outputs: o_pc_write=1, o_if_id_write=1, o_pipe_en=1, flush=0, bubble=0.

Optional Feature:
STEP_MODE_EN
- Defined: adds ports i_debug_mode (1) and i_step (1).
  - i_step is edge-detected by a register, giving one pulse per 0->1 transition.
  - With i_debug_mode=1, RUN moves to STEP_WAIT. In STEP_WAIT all enables are 0 (o_pc_write, o_if_id_write, o_pipe_en) and flush and bubble are 0.
  - A step pulse yields exactly one cycle of normal RUN/STALL evaluation, then returns to STEP_WAIT.
  - STALL and drain counters advance only on enabled cycles.
  - i_debug_mode=0 returns to RUN on the next cycle.
- Undefined: ports absent, STEP_WAIT unreachable, o_pipe_en=1 outside reset.

Decomposition:
- Package riesgos_pkg: state encoding constants, REG_ZERO=5'd0, default widths.
- One combinational sub-module, detector_load_use: comparator producing hz.
- The FSM, counters and output decode stay in the top module.

Test Plan:
- Load-use, MEM_LATENCY=1: EX lw $5; ID add with rs=5 -> one cycle with pc_write=0, if_id_write=0, bubble=1; next cycle all enables 1.
- MEM_LATENCY=3, same hazard -> stall held exactly 3 cycles; o_state = 1,1 then 0; i_ex_mem_read deasserted during the stall has no effect.
- lw $0 in EX; ID reads $0 -> no stall. i_uses_rt=0 with an rt match -> no stall.
- Hazard and i_branch_taken=1 in the same cycle -> stall without flush; the flush occurs in the first RUN cycle when the branch is still presented.
- i_halt in ID -> the HALT cycle has all enables 1; then pc_write=0 and bubble=1; o_halted=1 on the 4th cycle after HALT entry (PIPE_DEPTH=3); i_rst=0 mid-drain -> all outputs to reset values.
- STEP_MODE_EN: debug_mode=1 -> enables 0; one i_step pulse -> exactly one cycle with pipe_en=1; i_step held high -> no further cycles.
